// File: rtl/s32x_md_sync_gen_if.sv
// Bundles the mode inputs and timing outputs of the MD-side sync generator.
// The slave modport belongs to the generator; the master modport belongs to whoever drives the modes.
interface s32x_md_sync_gen_if;
  logic       ce;
  logic       pal;
  logic       h40;
  logic       v30;
  logic       ys_in;
  logic       edclk;
  logic       hsync_n;
  logic       vsync_n;
  logic       ys_n;
  logic       pix_ce;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       hblank;
  logic       vblank;

  modport master (
    output ce, pal, h40, v30, ys_in,
    input  edclk, hsync_n, vsync_n, ys_n, pix_ce, hcnt, vcnt, hblank, vblank
  );

  modport slave (
    input  ce, pal, h40, v30, ys_in,
    output edclk, hsync_n, vsync_n, ys_n, pix_ce, hcnt, vcnt, hblank, vblank
  );
endinterface

// File: rtl/s32x_md_sync_gen.sv
// MD-side video timing for the 32X VDP: divides MCLK into EDCLK and pixels, and pixels into
// lines and frames, producing HSYNC_N/VSYNC_N/YS_N plus the raster counters and blanking flags.
module s32x_md_sync_gen #(
  parameter int unsigned HS_LEN_H40 = 32,
  parameter int unsigned HS_LEN_H32 = 26,
  parameter int unsigned VS_LINES   = 3
) (
  input logic               clk,
  input logic               rst_n,
  s32x_md_sync_gen_if.slave bus
);

  logic       started_q, started_d;
  logic       h40_q, h40_d, pal_q, pal_d, v30_q, v30_d;
  logic [3:0] ph_q, ph_d;
  logic       edclk_q, edclk_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       ys_n_q, ys_n_d;
  logic       pix_ce_q, pix_ce_d;
  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;

  logic       h40_m, pal_m, v30_m;
  logic [3:0] ph_last;
  logic [8:0] h_last, v_last, h_act, v_act;
  logic [9:0] hs_start, hs_end, vs_start, vs_end;

  always_comb begin
    // Until the first CE after reset the live inputs stand in for the latched modes.
    h40_m    = started_q ? h40_q : bus.h40;
    pal_m    = started_q ? pal_q : bus.pal;
    v30_m    = started_q ? v30_q : bus.v30;
    ph_last  = h40_m ? 4'd7 : 4'd9;
    h_last   = h40_m ? 9'd419 : 9'd341;
    h_act    = h40_m ? 9'd320 : 9'd256;
    v_last   = pal_m ? 9'd312 : 9'd261;
    hs_start = h40_m ? 10'd345 : 10'd290;
    hs_end   = hs_start + (h40_m ? 10'(HS_LEN_H40) : 10'(HS_LEN_H32));
    vs_start = pal_m ? 10'd259 : 10'd235;
    vs_end   = vs_start + 10'(VS_LINES);

    started_d = started_q;
    h40_d     = h40_q;
    pal_d     = pal_q;
    v30_d     = v30_q;
    ph_d      = ph_q;
    edclk_d   = edclk_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;
    ys_n_d    = ys_n_q;
    pix_ce_d  = 1'b0;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    hblank_d  = hblank_q;
    vblank_d  = vblank_q;
    v_act     = 9'd224;

    if (bus.ce) begin
      started_d = 1'b1;
      if (!started_q) begin
        h40_d = bus.h40;
        pal_d = bus.pal;
        v30_d = bus.v30;
      end
      if (ph_q == ph_last) begin
        ph_d     = 4'd0;
        pix_ce_d = 1'b1;
        if (hcnt_q == h_last) begin
          hcnt_d = 9'd0;
          if (vcnt_q == v_last) begin
            // Frame wrap: ph_d is already 0, so the new H40 starts on a clean pixel.
            vcnt_d = 9'd0;
            h40_d  = bus.h40;
            pal_d  = bus.pal;
            v30_d  = bus.v30;
          end else begin
            vcnt_d = vcnt_q + 9'd1;
          end
        end else begin
          hcnt_d = hcnt_q + 9'd1;
        end
        v_act     = (pal_d && v30_d) ? 9'd240 : 9'd224;
        hblank_d  = (hcnt_d >= h_act);
        vblank_d  = (vcnt_d >= v_act);
        hsync_n_d = !(({1'b0, hcnt_d} >= hs_start) && ({1'b0, hcnt_d} < hs_end));
        if ({1'b0, hcnt_d} == hs_start) begin
          vsync_n_d = !(({1'b0, vcnt_d} >= vs_start) && ({1'b0, vcnt_d} < vs_end));
        end
        ys_n_d = !(bus.ys_in && !hblank_d && !vblank_d);
      end else begin
        ph_d = ph_q + 4'd1;
      end
      // Phase 0 is the low slot right after a pixel advance; each EDCLK period opens high.
      if (h40_m) begin
        edclk_d = ph_d[1];
      end else begin
        edclk_d = ((ph_d >= 4'd2) && (ph_d <= 4'd4)) || (ph_d >= 4'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      h40_q     <= 1'b0;
      pal_q     <= 1'b0;
      v30_q     <= 1'b0;
      ph_q      <= 4'd0;
      edclk_q   <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      ys_n_q    <= 1'b1;
      pix_ce_q  <= 1'b0;
      hcnt_q    <= 9'd0;
      vcnt_q    <= 9'd0;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
    end else begin
      started_q <= started_d;
      h40_q     <= h40_d;
      pal_q     <= pal_d;
      v30_q     <= v30_d;
      ph_q      <= ph_d;
      edclk_q   <= edclk_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      ys_n_q    <= ys_n_d;
      pix_ce_q  <= pix_ce_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
    end
  end

  assign bus.edclk   = edclk_q;
  assign bus.hsync_n = hsync_n_q;
  assign bus.vsync_n = vsync_n_q;
  assign bus.ys_n    = ys_n_q;
  assign bus.pix_ce  = pix_ce_q;
  assign bus.hcnt    = hcnt_q;
  assign bus.vcnt    = vcnt_q;
  assign bus.hblank  = hblank_q;
  assign bus.vblank  = vblank_q;

endmodule

// File: tb/tb_s32x_md_sync_gen.sv
// Directed bench for s32x_md_sync_gen: a negedge monitor records edges, periods and line events;
// the main sequence checks them against hand-computed timing for each mode.
module tb_s32x_md_sync_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  s32x_md_sync_gen_if bus ();

  s32x_md_sync_gen dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int ce_div = 1;
  int div_cnt = 0;
  bit mon_en = 1'b1;
  int exp_act = 320;
  int exp_va = 224;

  int cyc = 0, k_rel = 0;
  int rise_cyc = 0, fall_cyc = 0, hi_len = 0, lo_len = 0;
  int pix_cyc = 0, pix_per = 0, wrap_cyc = 0, line_len = 0, line_max = 0, frame_last_v = 0;
  int hs_fall_h = 0, hs_rise_h = 0, hs_fall_k = 0;
  int vs_fall_h = 0, vs_fall_v = 0, vs_rise_h = 0, vs_rise_v = 0;
  int vb_rise_v = 0, vb_rise_h = 0;
  int ys_bad = 0, ys_low = 0, ce_bad = 0;
  logic p_edclk = 1'b0, p_hsync = 1'b1, p_vsync = 1'b1, p_vblank = 1'b0;
  logic [8:0] p_hcnt = '0, p_vcnt = '0;
  logic [25:0] p_vec = '0;
  logic [15:0] ed_bits, pc_bits;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] out_vec();
    return {bus.edclk, bus.hsync_n, bus.vsync_n, bus.ys_n, bus.hcnt, bus.vcnt, bus.hblank,
            bus.vblank};
  endfunction

  // Monitor and CE generator share one process so CE is read before it is redriven.
  initial begin
    logic exp_ys;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) k_rel = 0;
      else k_rel++;
      if (rst_n && mon_en) begin
        if (bus.edclk && !p_edclk) begin lo_len = cyc - fall_cyc; rise_cyc = cyc; end
        if (!bus.edclk && p_edclk) begin hi_len = cyc - rise_cyc; fall_cyc = cyc; end
        if (bus.pix_ce) begin
          pix_per = cyc - pix_cyc;
          pix_cyc = cyc;
          exp_ys = !(bus.ys_in && (int'(bus.hcnt) < exp_act) && (int'(bus.vcnt) < exp_va));
          if (bus.ys_n !== exp_ys) ys_bad++;
          if (!bus.ys_n) ys_low++;
          if (bus.hcnt == 9'd0) begin
            line_len = cyc - wrap_cyc;
            wrap_cyc = cyc;
            line_max = int'(p_hcnt);
            if (bus.vcnt == 9'd0) frame_last_v = int'(p_vcnt);
          end
        end
        if (!bus.hsync_n && p_hsync) begin hs_fall_h = int'(bus.hcnt); hs_fall_k = k_rel; end
        if (bus.hsync_n && !p_hsync) hs_rise_h = int'(bus.hcnt);
        if (!bus.vsync_n && p_vsync) begin
          vs_fall_h = int'(bus.hcnt);
          vs_fall_v = int'(bus.vcnt);
        end
        if (bus.vsync_n && !p_vsync) begin
          vs_rise_h = int'(bus.hcnt);
          vs_rise_v = int'(bus.vcnt);
        end
        if (bus.vblank && !p_vblank) begin
          vb_rise_v = int'(bus.vcnt);
          vb_rise_h = int'(bus.hcnt);
        end
        if (!bus.ce && (out_vec() !== p_vec)) ce_bad++;
      end
      p_edclk = bus.edclk; p_hsync = bus.hsync_n; p_vsync = bus.vsync_n;
      p_vblank = bus.vblank; p_hcnt = bus.hcnt; p_vcnt = bus.vcnt; p_vec = out_vec();
      if (ce_div == 0) bus.ce = 1'b0;
      else if (ce_div == 1) bus.ce = 1'b1;
      else begin
        bus.ce = (div_cnt == 0);
        div_cnt = (div_cnt + 1) % ce_div;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reposition the raster with CE held off, so the bench can reach late lines quickly.
  task automatic jump(input logic [8:0] h, input logic [8:0] v);
    mon_en = 1'b0;
    ce_div = 0;
    @(negedge clk);
    force dut.hcnt_q = h;
    force dut.vcnt_q = v;
    @(negedge clk);
    release dut.hcnt_q;
    release dut.vcnt_q;
    @(negedge clk);
    ce_div = 1;
    mon_en = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bus.ce = 1'b1; bus.h40 = 1'b1; bus.pal = 1'b0; bus.v30 = 1'b0; bus.ys_in = 1'b1;
    run(3);
    check_eq("rst_edclk", bus.edclk, 1'b0);
    check_eq("rst_hsync", bus.hsync_n, 1'b1);
    check_eq("rst_vsync", bus.vsync_n, 1'b1);
    check_eq("rst_ys", bus.ys_n, 1'b1);
    check_eq("rst_pixce", bus.pix_ce, 1'b0);
    check_eq("rst_cnt", {bus.hcnt, bus.vcnt}, 18'd0);
    check_eq("rst_blank", {bus.hblank, bus.vblank}, 2'b00);
    #2 rst_n = 1'b1;

    // H40 NTSC, CE every cycle.
    for (int k = 1; k <= 7000; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        ed_bits[16-k] = bus.edclk;
        pc_bits[16-k] = bus.pix_ce;
      end
      if (k == 2552) check_eq("h40_ys_px319", {bus.ys_n, bus.hblank}, 2'b00);
      if (k == 2560) check_eq("h40_ys_px320", {bus.ys_n, bus.hblank}, 2'b11);
    end
    check_eq("h40_edclk_wave", ed_bits, 16'b0110_0110_0110_0110);
    check_eq("h40_pixce_wave", pc_bits, 16'b0000_0001_0000_0001);
    check_eq("h40_hcnt", bus.hcnt, 9'd35);
    check_eq("h40_vcnt", bus.vcnt, 9'd2);
    check_eq("h40_hs_fall", hs_fall_h, 345);
    check_eq("h40_hs_rise", hs_rise_h, 377);
    check_eq("h40_line_clk", line_len, 3360);
    check_eq("h40_line_max", line_max, 419);
    check_eq("h40_ed_hi", hi_len, 2);
    check_eq("h40_ed_lo", lo_len, 2);
    check_eq("h40_pix_per", pix_per, 8);

    jump(9'd400, 9'd223);
    run(200);
    check_eq("ntsc_vb_rise_v", vb_rise_v, 224);
    check_eq("ntsc_vb_rise_h", vb_rise_h, 0);
    jump(9'd300, 9'd234);
    run(14000);
    check_eq("ntsc_vs_fall_v", vs_fall_v, 235);
    check_eq("ntsc_vs_fall_h", vs_fall_h, 345);
    check_eq("ntsc_vs_rise_v", vs_rise_v, 238);
    check_eq("ntsc_vs_rise_h", vs_rise_h, 345);

    // H40 dropped mid-frame takes effect only at the frame wrap.
    bus.ys_in = 1'b0;
    jump(9'd400, 9'd100);
    bus.h40 = 1'b0;
    run(300);
    check_eq("midswap_line_max", line_max, 419);
    check_eq("midswap_vcnt", bus.vcnt, 9'd101);
    check_eq("midswap_pix_per", pix_per, 8);
    jump(9'd410, 9'd261);
    run(3700);
    check_eq("swap_frame_last", frame_last_v, 261);
    check_eq("swap_vcnt", bus.vcnt, 9'd1);
    check_eq("swap_line_max", line_max, 341);
    check_eq("swap_line_clk", line_len, 3420);
    check_eq("swap_pix_per", pix_per, 10);

    // H32 PAL V30.
    bus.pal = 1'b1; bus.v30 = 1'b1; bus.ys_in = 1'b1;
    exp_act = 256; exp_va = 240;
    do_reset();
    run(3500);
    check_eq("h32_hs_fall", hs_fall_h, 290);
    check_eq("h32_hs_rise", hs_rise_h, 316);
    check_eq("h32_ed_hi", hi_len, 3);
    check_eq("h32_ed_lo", lo_len, 2);
    check_eq("h32_pix_per", pix_per, 10);
    jump(9'd330, 9'd5);
    run(3700);
    check_eq("h32_line_clk", line_len, 3420);
    check_eq("h32_vcnt", bus.vcnt, 9'd7);
    jump(9'd335, 9'd239);
    run(150);
    check_eq("pal_vb_rise_v", vb_rise_v, 240);
    jump(9'd280, 9'd258);
    run(14000);
    check_eq("pal_vs_fall_v", vs_fall_v, 259);
    check_eq("pal_vs_fall_h", vs_fall_h, 290);
    check_eq("pal_vs_rise_v", vs_rise_v, 262);
    check_eq("pal_vs_rise_h", vs_rise_h, 290);
    jump(9'd335, 9'd312);
    run(150);
    check_eq("pal_frame_last", frame_last_v, 312);
    check_eq("pal_wrap_state", {bus.vcnt, bus.vblank, bus.vsync_n}, {9'd0, 1'b0, 1'b1});

    // CE at 1/3 duty: everything stretches by three CLKs.
    ce_div = 3;
    run(600);
    check_eq("ce3_ed_hi", hi_len, 9);
    check_eq("ce3_ed_lo", lo_len, 6);
    check_eq("ce3_pix_per", pix_per, 30);
    check_eq("ce3_hold", ce_bad, 0);

    // Asynchronous reset mid-frame, then restart in H40 NTSC.
    bus.h40 = 1'b1; bus.pal = 1'b0; bus.v30 = 1'b0;
    exp_act = 320; exp_va = 224;
    jump(9'd200, 9'd150);
    run(20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_flags", {bus.edclk, bus.hsync_n, bus.vsync_n, bus.ys_n, bus.pix_ce,
                            bus.hblank, bus.vblank}, 7'b0111000);
    check_eq("arst_cnt", {bus.hcnt, bus.vcnt}, 18'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(2800);
    check_eq("arst_hs_k", hs_fall_k, 2760);
    check_eq("arst_hs_h", hs_fall_h, 345);

    check_eq("ys_model", ys_bad, 0);
    check_eq("ys_seen_low", ys_low > 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/s32x_md_sync_gen.md
Name: s32x_md_sync_gen

Overview:
- Generates the MD-side video timing that the 32X VDP consumes: EDCLK, HSYNC_N, VSYNC_N and YS_N.
- Used as the MD VDP timing source in the standalone 32X build and in the VDP test bench.
- Counts master clocks into pixels, pixels into lines, and lines into frames, for H40/H32 and NTSC/PAL (V28/V30).
- Also exports its own raster counters and blanking flags for debug and overlay logic.

Parameters:
- HS_LEN_H40, 32, HSYNC_N low width in pixels for H40.
- HS_LEN_H32, 26, HSYNC_N low width in pixels for H32.
- VS_LINES, 3, VSYNC_N low width in lines.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  master-clock (MCLK) enable; one MCLK tick per cycle with CE=1
- PAL  in  1  1 = 313-line frame, 0 = 262-line frame
- H40  in  1  1 = 320-pixel mode, 0 = 256-pixel mode
- V30  in  1  240 active lines; honoured only when PAL=1
- YS_IN  in  1  MD pixel transparency (1 = MD backdrop, 32X may show)
- EDCLK  out  1  external dot clock, 2 periods per pixel
- HSYNC_N  out  1  horizontal sync, active low
- VSYNC_N  out  1  vertical sync, active low
- YS_N  out  1  registered YS_IN, forced 1 in blanking
- PIX_CE  out  1  one-CLK pulse on each pixel advance
- HCNT  out  9  pixel counter
- VCNT  out  9  line counter
- HBLANK  out  1  horizontal blanking flag
- VBLANK  out  1  vertical blanking flag

Behaviour:
- Reset values: EDCLK=0, HSYNC_N=1, VSYNC_N=1, YS_N=1, PIX_CE=0, HCNT=0, VCNT=0, HBLANK=0, VBLANK=0, phase counter=0.
- Reset is asynchronous at any point mid-frame; counting restarts at HCNT=0, VCNT=0 with the modes sampled at the next CE.
- All state advances only on cycles with CE=1. PIX_CE is a single-CLK pulse.
- EDCLK waveform (per MCLK):
  - H40: high 2 CE, low 2 CE (period 4).
  - H32: high 3 CE, low 2 CE (period 5).
  - Each EDCLK period starts with its rising edge.
- Pixel advance: on every 2nd EDCLK falling edge, i.e. 8 MCLK per pixel in H40 and 10 in H32. PIX_CE pulses in the same cycle as that falling edge.
- HCNT range: 0..TOTAL-1, then wraps to 0 and VCNT increments.
  - TOTAL = 420 (H40) or 342 (H32).
  - Pixel 0 is the first active pixel.
  - Active width ACT = 320 (H40) or 256 (H32).
- HBLANK = (HCNT >= ACT).
- HSYNC_N = 0 for HCNT in [HS_START, HS_START+HS_LEN-1].
  - HS_START = 345 (H40) or 290 (H32); HS_LEN comes from the parameters.
  - HSYNC_N changes only together with a pixel advance.
- VCNT range: 0..261 (NTSC) or 0..312 (PAL), then wraps to 0.
  - Active lines VA = 240 if PAL&V30, else 224.
  - VBLANK = (VCNT >= VA); it changes only at HCNT wrap.
- VSYNC_N falls at HCNT=HS_START of line VS_START, where VS_START = 235 (NTSC) or 259 (PAL). It stays low for VS_LINES lines and rises at HCNT=HS_START of line VS_START+VS_LINES.
- Mode latching: H40, PAL and V30 are latched only at the frame wrap (VCNT wrap to 0, HCNT=0), so a mode change mid-frame never produces a short or long line.
  - H40 is latched only on a pixel boundary.
  - The EDCLK phase counter restarts at the latch.
- YS_N: on each pixel advance, YS_N <= YS_IN & ~HBLANK & ~VBLANK, inverted to active-low form: YS_N = ~(YS_IN & active). Outside the active area YS_N = 1.
- HCNT, VCNT, HBLANK and VBLANK update in the PIX_CE cycle and are registered.
- Simultaneous events: when HCNT and VCNT wrap together, the mode latch, the VBLANK clear and the VSYNC evaluation all use the new values.

Test Plan:
- Reset release, H40 NTSC, CE=1 continuously:
  - EDCLK toggles 2/2.
  - PIX_CE every 8 CLK.
  - HSYNC_N low from HCNT 345 to 376.
  - Line length 3360 CLK.
- H32 PAL V30:
  - EDCLK high 3 / low 2.
  - Line length 3420 CE.
  - Frame length 313 lines.
  - VBLANK rises at VCNT=240.
  - VSYNC_N low over lines 259..261 starting at HCNT 290.
- CE duty 1/3: all timing scales by 3 in CLK, and no output changes on cycles with CE=0.
- H40 toggled to 0 at VCNT=100: the line length stays 420 pixels until the frame wrap, then becomes 342 from line 0.
- YS_IN=1 constant: YS_N=0 only for HCNT<320 and VCNT<224, and 1 elsewhere.
- Reset asserted at VCNT=150, HCNT=200: all outputs take their reset values immediately; after release, the first HSYNC_N falls 345 pixels later.
